burst_sequencer: RTL

BURST_SEQUENCER -- requirements
Module: burst_sequencer

---
 rtl/burst_seq_pkg.sv | 37 +++
 rtl/burst_seq_timer.sv | 26 ++
 rtl/burst_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/burst_seq_pkg.sv
// rtl/burst_seq_pkg.sv - shared states, register map and status decode for burst_sequencer
package burst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        XFER,
        CAPTURE,
        CLEAR,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_FIFO = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_MEM  = 2'd2;

    localparam int FULL  = 0;
    localparam int EMPTY = 1;
    localparam int OVF   = 2;
    localparam int UDF   = 3;

    localparam logic [7:0] STAT_CLR = 8'h10;

    // Returns {fault, go} for one status sample; fault wins over go at the caller.
    function automatic logic [1:0] poll_decode(
        input logic [3:0] flags,
        input logic       is_write,
        input logic       wr_avail
    );
        logic fault;
        logic go;
        fault = flags[OVF] | flags[UDF];
        go    = is_write ? (~flags[FULL] & wr_avail) : ~flags[EMPTY];
        return {fault, go};
    endfunction

endpackage

// File: rtl/burst_seq_timer.sv
// rtl/burst_seq_timer.sv - counts consecutive stalled status polls and flags the abort point
module burst_seq_timer
    import burst_seq_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic expired
);

    logic [7:0] count;

    // Any cycle that is not a stalled poll breaks the run of failures.
    always_ff @(posedge clk) begin
        if (rst || !stall) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign expired = stall && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/burst_sequencer.sv
// rtl/burst_sequencer.sv - polled FIFO burst engine; BURST_SEQ_TIMEOUT_EN adds a status-poll timeout
module burst_sequencer
    import burst_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [3:0] cmd_len,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       err,
    output logic       enable,
    output logic [1:0] addr,
    output logic       write,
    output logic       read,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);

    state_t     state;
    state_t     state_nx;
    logic       is_write;
    logic [4:0] beats;
    logic       err_q;
    logic       last_beat;
    logic       poll_fault;
    logic       poll_go;
    logic       timeout;

    logic       enable_raw;
    logic [1:0] addr_raw;
    logic       write_raw;
    logic       read_raw;
    logic [7:0] wdata_raw;
    logic       wr_ready_raw;

    assign {poll_fault, poll_go} = poll_decode(rdata[3:0], is_write, wr_valid);
    assign last_beat = (beats == 5'd1);

`ifdef BURST_SEQ_TIMEOUT_EN
    logic poll_stall;

    assign poll_stall = (state == POLL) && !poll_fault && !poll_go && !rst;

    burst_seq_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .stall  (poll_stall),
        .expired(timeout)
    );
`else
    // Without the timer the poll loop never gives up on a busy status.
    assign timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            is_write <= 1'b0;
            beats    <= 5'd0;
            err_q    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            state    <= state_nx;
            rd_valid <= (state == CAPTURE);
            rd_data  <= (state == CAPTURE) ? rdata : 8'h00;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_write <= cmd_write;
                        beats    <= {1'b0, cmd_len} + 5'd1;
                        err_q    <= 1'b0;
                    end
                end
                POLL: begin
                    if (poll_fault || timeout) begin
                        err_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (is_write) begin
                        beats <= beats - 5'd1;
                    end
                end
                CAPTURE: beats <= beats - 5'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx     = state;
        enable_raw   = 1'b0;
        addr_raw     = ADDR_FIFO;
        write_raw    = 1'b0;
        read_raw     = 1'b0;
        wdata_raw    = 8'h00;
        wr_ready_raw = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = POLL;
                end
            end
            POLL: begin
                enable_raw = 1'b1;
                addr_raw   = ADDR_STAT;
                read_raw   = 1'b1;
                if (poll_fault) begin
                    state_nx = CLEAR;
                end else if (poll_go) begin
                    state_nx = XFER;
                end else if (timeout) begin
                    state_nx = CLEAR;
                end
            end
            XFER: begin
                enable_raw = 1'b1;
                addr_raw   = ADDR_FIFO;
                if (is_write) begin
                    write_raw    = 1'b1;
                    wdata_raw    = wr_data;
                    wr_ready_raw = 1'b1;
                    state_nx     = last_beat ? DONE : POLL;
                end else begin
                    read_raw = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: state_nx = last_beat ? DONE : POLL;
            CLEAR: begin
                enable_raw = 1'b1;
                addr_raw   = ADDR_STAT;
                write_raw  = 1'b1;
                wdata_raw  = STAT_CLR;
                state_nx   = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reset silences the downstream port within the same cycle it is raised.
    assign enable    = enable_raw & ~rst;
    assign addr      = rst ? ADDR_FIFO : addr_raw;
    assign write     = write_raw & ~rst;
    assign read      = read_raw & ~rst;
    assign wdata     = rst ? 8'h00 : wdata_raw;
    assign wr_ready  = wr_ready_raw & ~rst;
    assign cmd_ready = (state == IDLE) & ~rst;
    assign done      = (state == DONE) & ~rst;
    assign err       = done & err_q;

endmodule
